status_flag_unit: RTL and testbench

- Producer side of the NZCV condition-flag interface. Holds the architectural status register written by the EXE stage and the MSR-style direct write path. Drives the 4-bit status bus {N,Z,C,V} that the condition checker consumes.
- Tracks flag-setting instructions in flight between ID and EXE. Raises flags_busy so the hazard unit can stall conditional instructions until the status value they need is architectural.

---
 rtl/status_flag_unit.sv | 120 ++++++++++++
 tb/tb_status_flag_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_flag_unit.sv
// NZCV status register and in-flight flag-writer tracker.
// Optional STATUS_FLAG_FORWARD_EN: expose next-state flags and early busy release.
module status_flag_unit #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       flush,
    input  logic       id_issue_s,
    input  logic       exe_valid,
    input  logic       exe_s,
    input  logic [3:0] exe_flags,
    input  logic [3:0] exe_mask,
    input  logic       msr_we,
    input  logic [3:0] msr_data,
    output logic [3:0] status_out,
    output logic       flags_busy,
    output logic       inflight_full,
    output logic       ovf_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [3:0]       status_q;
    logic [3:0]       status_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_err_q;
    logic             ovf_err_d;

    logic upd;
    logic msr_wr;
    logic inc;
    logic dec;
    logic act;
    logic go;

    always_comb begin
        upd    = exe_valid & exe_s & ~freeze;
        msr_wr = msr_we & ~freeze;
        act    = ~freeze;
        go     = act & ~flush;
        inc    = id_issue_s;
        dec    = upd;
    end

    // MSR write takes precedence over the ALU flag update.
    always_comb begin
        status_d = status_q;
        unique case (1'b1)
            msr_wr:
                status_d = msr_data;
            ~msr_wr & upd:
                status_d = (exe_mask & exe_flags)
                         | (~exe_mask & status_q);
            default: ;
        endcase
    end

    // Saturating counter; an attempted over/underflow latches ovf_err.
    always_comb begin
        count_d   = count_q;
        ovf_err_d = ovf_err_q;
        unique case (1'b1)
            ~act: ;
            act & flush:
                count_d = '0;
            go & inc & ~dec: begin
                if (count_q < MAX_CNT) begin
                    count_d = count_q + ONE_CNT;
                end else begin
                    ovf_err_d = 1'b1;
                end
            end
            go & dec & ~inc: begin
                if (count_q != '0) begin
                    count_d = count_q - ONE_CNT;
                end else begin
                    ovf_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= 4'b0000;
            count_q   <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            count_q   <= count_d;
            ovf_err_q <= ovf_err_d;
        end
    end

`ifdef STATUS_FLAG_FORWARD_EN
    // Retiring writer releases its consumer in the same cycle.
    always_comb begin
        status_out = status_d;
        flags_busy = (count_q > ONE_CNT)
                   | ((count_q == ONE_CNT) & ~upd);
    end
`else
    always_comb begin
        status_out = status_q;
        flags_busy = (count_q != '0);
    end
`endif

    always_comb begin
        inflight_full = (count_q == MAX_CNT);
        ovf_err       = ovf_err_q;
    end

endmodule

// File: tb/tb_status_flag_unit.sv
// Randomized + directed bench for status_flag_unit against a behavioural model.
// Define STATUS_FLAG_FORWARD_EN on both to check the forwarding build.
module tb_status_flag_unit;

    localparam int MAXF = 3;

    logic       clk;
    logic       rst;
    logic       freeze;
    logic       flush;
    logic       id_issue_s;
    logic       exe_valid;
    logic       exe_s;
    logic [3:0] exe_flags;
    logic [3:0] exe_mask;
    logic       msr_we;
    logic [3:0] msr_data;
    logic [3:0] status_out;
    logic       flags_busy;
    logic       inflight_full;
    logic       ovf_err;

    int checks;
    int failures;

    // reference model state
    bit [3:0] m_st;
    int       m_cnt;
    bit       m_ovf;

    status_flag_unit #(
        .MAX_INFLIGHT(MAXF),
        .CNT_W       (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .id_issue_s   (id_issue_s),
        .exe_valid    (exe_valid),
        .exe_s        (exe_s),
        .exe_flags    (exe_flags),
        .exe_mask     (exe_mask),
        .msr_we       (msr_we),
        .msr_data     (msr_data),
        .status_out   (status_out),
        .flags_busy   (flags_busy),
        .inflight_full(inflight_full),
        .ovf_err      (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        freeze     = 1'b0;
        flush      = 1'b0;
        id_issue_s = 1'b0;
        exe_valid  = 1'b0;
        exe_s      = 1'b0;
        exe_flags  = 4'h0;
        exe_mask   = 4'h0;
        msr_we     = 1'b0;
        msr_data   = 4'h0;
    endtask

    task automatic settle();
        idle_in();
        #1;
    endtask

    // Applies current inputs for one clock, checking outputs before the edge.
    task automatic step();
        bit       upd;
        bit [3:0] n_st;
        int       n_cnt;
        bit       n_ovf;
        bit       busy_e;
        #1;
        upd   = exe_valid && exe_s && !freeze;
        n_st  = m_st;
        n_cnt = m_cnt;
        n_ovf = m_ovf;
        if (!freeze && msr_we) begin
            n_st = msr_data;
        end else if (upd) begin
            for (int i = 0; i < 4; i++)
                if (exe_mask[i]) n_st[i] = exe_flags[i];
        end
        if (!freeze) begin
            if (flush) begin
                n_cnt = 0;
            end else if (id_issue_s && !upd) begin
                if (m_cnt == MAXF) n_ovf = 1;
                else n_cnt = m_cnt + 1;
            end else if (upd && !id_issue_s) begin
                if (m_cnt == 0) n_ovf = 1;
                else n_cnt = m_cnt - 1;
            end
        end
        if (rst) begin
            n_st  = 4'h0;
            n_cnt = 0;
            n_ovf = 0;
        end else begin
`ifdef STATUS_FLAG_FORWARD_EN
            check("fwd_status", 32'(status_out), 32'(n_st));
            busy_e = (m_cnt > 1) || (m_cnt == 1 && !upd);
`else
            check("status", 32'(status_out), 32'(m_st));
            busy_e = (m_cnt != 0);
`endif
            check("busy", 32'(flags_busy), 32'(busy_e));
            check("full", 32'(inflight_full), 32'(m_cnt == MAXF));
            check("ovf", 32'(ovf_err), 32'(m_ovf));
        end
        @(posedge clk);
        #1;
        m_st  = n_st;
        m_cnt = n_cnt;
        m_ovf = n_ovf;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in();
            id_issue_s = 1'b1;
            step();
        end
    endtask

    task automatic retire(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in();
            exe_valid = 1'b1;
            exe_s     = 1'b1;
            exe_mask  = 4'hF;
            exe_flags = m_st;
            step();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_st     = '0;
        m_cnt    = 0;
        m_ovf    = 0;

        // reset state
        do_reset();
        settle();
        check("rst_status", 32'(status_out), 32'h0);
        check("rst_busy", 32'(flags_busy), 32'h0);
        check("rst_full", 32'(inflight_full), 32'h0);
        check("rst_ovf", 32'(ovf_err), 32'h0);

        // masked update preserves V
        msr_we = 1'b1; msr_data = 4'b0001;
        step();
        idle_in();
        exe_valid = 1'b1; exe_s = 1'b1;
        exe_flags = 4'b1100; exe_mask = 4'b1110;
        step();
        settle();
        check("mask_upd", 32'(status_out), 32'b1101);
        exe_valid = 1'b1; exe_s = 1'b0;
        exe_flags = 4'b0010; exe_mask = 4'b1111;
        step();
        settle();
        check("no_s_hold", 32'(status_out), 32'b1101);

        // MSR beats simultaneous EXE update
        do_reset();
        msr_we = 1'b1; msr_data = 4'b0010;
        exe_valid = 1'b1; exe_s = 1'b1;
        exe_flags = 4'b1111; exe_mask = 4'b1111;
        step();
        settle();
        check("msr_prio", 32'(status_out), 32'b0010);

        // counter saturation
        do_reset();
        issue(3);
        settle();
        check("full3", 32'(inflight_full), 32'h1);
        check("busy3", 32'(flags_busy), 32'h1);
        issue(1);
        settle();
        check("full4", 32'(inflight_full), 32'h1);
        check("ovf_issue", 32'(ovf_err), 32'h1);

        do_reset();
        issue(3);
        idle_in();
        id_issue_s = 1'b1; exe_valid = 1'b1; exe_s = 1'b1;
        step();
        settle();
        check("inc_dec_full", 32'(inflight_full), 32'h1);
        check("inc_dec_ovf", 32'(ovf_err), 32'h0);
        retire(3);
        settle();
        check("drain_busy", 32'(flags_busy), 32'h0);
        check("drain_ovf", 32'(ovf_err), 32'h0);

        // flush, freeze, underflow
        do_reset();
        issue(2);
        idle_in();
        flush = 1'b1; id_issue_s = 1'b1;
        step();
        settle();
        check("flush_busy", 32'(flags_busy), 32'h0);
        issue(1);
        idle_in();
        freeze = 1'b1; msr_we = 1'b1; msr_data = 4'hF;
        exe_valid = 1'b1; exe_s = 1'b1;
        exe_flags = 4'hF; exe_mask = 4'hF;
        step();
        settle();
        check("frz_status", 32'(status_out), 32'h0);
        check("frz_busy", 32'(flags_busy), 32'h1);
        idle_in();
        flush = 1'b1;
        step();
        retire(1);
        settle();
        check("under_ovf", 32'(ovf_err), 32'h1);

        // same-cycle visibility of a retiring write
        do_reset();
        issue(1);
        idle_in();
        exe_valid = 1'b1; exe_s = 1'b1;
        exe_flags = 4'b0100; exe_mask = 4'b1111;
        #1;
`ifdef STATUS_FLAG_FORWARD_EN
        check("fwd_now", 32'(status_out), 32'b0100);
        check("fwd_busy", 32'(flags_busy), 32'h0);
`else
        check("reg_now", 32'(status_out), 32'b0000);
        check("reg_busy", 32'(flags_busy), 32'h1);
`endif
        step();
        settle();
        check("upd_after", 32'(status_out), 32'b0100);
        check("busy_after", 32'(flags_busy), 32'h0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            idle_in();
            rst        = ($urandom_range(0, 79) == 0);
            freeze     = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            id_issue_s = ($urandom_range(0, 1) == 1) &&
                         (m_cnt < MAXF || $urandom_range(0, 9) == 0);
            exe_valid  = ($urandom_range(0, 3) != 0);
            exe_s      = ($urandom_range(0, 1) == 1) &&
                         (m_cnt > 0 || $urandom_range(0, 9) == 0);
            exe_flags  = 4'($urandom);
            exe_mask   = 4'($urandom);
            msr_we     = ($urandom_range(0, 9) == 0);
            msr_data   = 4'($urandom);
            step();
        end
        rst = 1'b0;
        settle();
        check("final_status", 32'(status_out), 32'(m_st));
        check("final_ovf", 32'(ovf_err), 32'(m_ovf));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
